// File: rtl/tx_fifo_serializer.sv
// tx_fifo_serializer: buffered multi-lane serial transmitter for a router output port.
//
// Flits enter a DEPTH-entry FIFO through a valid/ready handshake. Each flit is then sent on
// LANES serial wires as one all-ones start beat followed by WIDTH/LANES data beats, LSB first.
// A frame is launched only from idle and only while the downstream channel is not busy.
//
// Optional feature macro: TX_PARITY_EN appends one even-parity beat per lane after the data.
//
// Ports:
//   clk_i           clock
//   reset_i         synchronous reset, active-high
//   in_valid_i      in_data_i is offered
//   in_ready_o      FIFO can accept this cycle
//   in_data_i       flit to transmit
//   channel_busy_i  downstream link occupied; only looked at when launching a frame
//   serial_out_o    serial beat, all zero when not transmitting
//   tx_active_o     a frame is on the wire
//   fifo_count_o    number of stored flits
module tx_fifo_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LANES = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH-1:0]           in_data_i,
   input  logic                       channel_busy_i,
   output logic [LANES-1:0]           serial_out_o,
   output logic                       tx_active_o,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

   localparam int unsigned Beats = WIDTH / LANES;
   localparam int unsigned BeatW = $clog2(Beats + 3);
   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {StIdle, StSend} state_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             push, pop;

   state_e           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [BeatW-1:0] beat_q;
   logic [LANES-1:0] serial_q;
   logic             tx_active_q;
`ifdef TX_PARITY_EN
   logic [LANES-1:0] parity_q;
`endif

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // in_ready depends only on the registered count, so a pop at full does not open the input.
   assign in_ready_o = ~reset_i & (count_q < CntW'(DEPTH));
   assign push       = in_valid_i & in_ready_o;
   // Launch pops the head; count_q only reflects earlier pushes, so there is no bypass.
   assign pop        = (state_q == StIdle) & (count_q != '0) & ~channel_busy_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // beat_q numbers the beat currently on the wire: 0 = start, 1..Beats = data, Beats+1 = parity.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         beat_q      <= '0;
         serial_q    <= '0;
         tx_active_q <= 1'b0;
`ifdef TX_PARITY_EN
         parity_q    <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (pop) begin
                  shift_q     <= mem_q[rd_ptr_q];
                  beat_q      <= '0;
                  serial_q    <= '1;
                  tx_active_q <= 1'b1;
                  state_q     <= StSend;
`ifdef TX_PARITY_EN
                  parity_q    <= '0;
`endif
               end
            end
            StSend: begin
               if (beat_q < BeatW'(Beats)) begin
                  serial_q <= shift_q[LANES-1:0];
                  shift_q  <= shift_q >> LANES;
                  beat_q   <= beat_q + 1'b1;
`ifdef TX_PARITY_EN
                  parity_q <= parity_q ^ shift_q[LANES-1:0];
`endif
`ifdef TX_PARITY_EN
               end else if (beat_q == BeatW'(Beats)) begin
                  serial_q <= parity_q;
                  beat_q   <= beat_q + 1'b1;
`endif
               end else begin
                  serial_q    <= '0;
                  shift_q     <= '0;
                  beat_q      <= '0;
                  tx_active_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign serial_out_o = serial_q & {LANES{tx_active_q}};
   assign tx_active_o  = tx_active_q;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_tx_fifo_serializer.sv
// Directed bench for tx_fifo_serializer: one instance with LANES=1 and one with LANES=2.
// Expected beats are queued when a flit is offered and checked every cycle the DUT transmits.
module tb_tx_fifo_serializer;

`ifdef TX_PARITY_EN
   localparam int unsigned Par = 1;
`else
   localparam int unsigned Par = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       a_valid, a_ready, a_busy, a_ser, a_tx;
   logic [7:0] a_data;
   logic [2:0] a_cnt;
   logic       b_valid, b_ready, b_busy, b_tx;
   logic [7:0] b_data;
   logic [1:0] b_ser;
   logic [2:0] b_cnt;

   int         total = 0;
   int         bad   = 0;
   int         act_a = 0;
   int         act_b = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   always #5 clk = ~clk;

   tx_fifo_serializer #(.WIDTH(8), .LANES(1), .DEPTH(4)) u_dut_a (
      .clk_i          (clk),
      .reset_i        (reset),
      .in_valid_i     (a_valid),
      .in_ready_o     (a_ready),
      .in_data_i      (a_data),
      .channel_busy_i (a_busy),
      .serial_out_o   (a_ser),
      .tx_active_o    (a_tx),
      .fifo_count_o   (a_cnt)
   );

   tx_fifo_serializer #(.WIDTH(8), .LANES(2), .DEPTH(4)) u_dut_b (
      .clk_i          (clk),
      .reset_i        (reset),
      .in_valid_i     (b_valid),
      .in_ready_o     (b_ready),
      .in_data_i      (b_data),
      .channel_busy_i (b_busy),
      .serial_out_o   (b_ser),
      .tx_active_o    (b_tx),
      .fifo_count_o   (b_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_a(input logic [7:0] d);
      qa.push_back(8'h01);
      for (int k = 0; k < 8; k++) qa.push_back({7'b0, d[k]});
      if (Par != 0) qa.push_back({7'b0, ^d});
   endtask

   task automatic expect_b(input logic [7:0] d);
      qb.push_back(8'h03);
      for (int k = 0; k < 4; k++) qb.push_back({6'b0, d[2*k+1], d[2*k]});
      if (Par != 0) qb.push_back({6'b0, d[1] ^ d[3] ^ d[5] ^ d[7], d[0] ^ d[2] ^ d[4] ^ d[6]});
   endtask

   // One clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (a_tx) begin
         act_a++;
         chk("a_beat_expected", 32'(qa.size() > 0), 32'd1);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_beat", 32'(a_ser), 32'(e));
         end
      end else begin
         chk("a_idle_zero", 32'(a_ser), 32'd0);
      end
      if (b_tx) begin
         act_b++;
         chk("b_beat_expected", 32'(qb.size() > 0), 32'd1);
         if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_beat", 32'(b_ser), 32'(e));
         end
      end else begin
         chk("b_idle_zero", 32'(b_ser), 32'd0);
      end
   endtask

   task automatic wait_idle_a(input int budget);
      int n = 0;
      while ((a_tx || a_cnt != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("a_idle_timeout", 32'(a_tx || a_cnt != 0), 32'd0);
   endtask

   task automatic wait_idle_b(input int budget);
      int n = 0;
      while ((b_tx || b_cnt != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("b_idle_timeout", 32'(b_tx || b_cnt != 0), 32'd0);
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      a_valid = 1'b0; a_data = '0; a_busy = 1'b0;
      b_valid = 1'b0; b_data = '0; b_busy = 1'b0;

      // Reset state
      #1;
      chk("rst_in_ready_low", 32'(a_ready), 32'd0);
      tick();
      chk("rst_count", 32'(a_cnt), 32'd0);
      chk("rst_tx_active", 32'(a_tx), 32'd0);
      chk("rst_in_ready_held", 32'(a_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("in_ready_after_rst", 32'(a_ready), 32'd1);

      // 1: single flit 0xA5, one lane
      act_a = 0;
      a_valid = 1'b1; a_data = 8'hA5; expect_a(8'hA5);
      tick();
      a_valid = 1'b0;
      chk("t1_count_after_push", 32'(a_cnt), 32'd1);
      chk("t1_no_bypass", 32'(a_tx), 32'd0);
      wait_idle_a(40);
      chk("t1_frame_len", 32'(act_a), 32'(9 + Par));
      chk("t1_queue_drained", 32'(qa.size()), 32'd0);

      // 2: 0xA5 on two lanes
      act_b = 0;
      b_valid = 1'b1; b_data = 8'hA5; expect_b(8'hA5);
      tick();
      b_valid = 1'b0;
      wait_idle_b(40);
      chk("t2_frame_len", 32'(act_b), 32'(5 + Par));
      chk("t2_queue_drained", 32'(qb.size()), 32'd0);

      // 3: back-to-back pushes, exactly one idle cycle between frames
      act_a = 0;
      a_valid = 1'b1; a_data = 8'h01; expect_a(8'h01);
      tick();
      chk("t3_count_1", 32'(a_cnt), 32'd1);
      a_data = 8'h02; expect_a(8'h02);
      tick();
      a_valid = 1'b0;
      chk("t3_count_push_pop", 32'(a_cnt), 32'd1);
      chk("t3_first_launch", 32'(a_tx), 32'd1);
      n = 0;
      while (a_tx && n < 40) begin
         tick();
         n++;
      end
      chk("t3_gap_idle", 32'(a_tx), 32'd0);
      tick();
      chk("t3_second_launch", 32'(a_tx), 32'd1);
      chk("t3_count_0", 32'(a_cnt), 32'd0);
      wait_idle_a(40);
      chk("t3_total_active", 32'(act_a), 32'(2 * (9 + Par)));

      // 4: fill while busy, fifth flit held until the first pop
      a_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a_valid = 1'b1;
         a_data  = 8'h10 + 8'(i);
         chk("t4_in_ready_fill", 32'(a_ready), 32'(i < 4));
         if (i < 4) expect_a(8'h10 + 8'(i));
         tick();
      end
      chk("t4_count_full", 32'(a_cnt), 32'd4);
      chk("t4_in_ready_full", 32'(a_ready), 32'd0);
      chk("t4_no_launch_busy", 32'(a_tx), 32'd0);
      a_busy = 1'b0;
      tick();
      chk("t4_count_after_pop", 32'(a_cnt), 32'd3);
      chk("t4_launch", 32'(a_tx), 32'd1);
      chk("t4_in_ready_reopen", 32'(a_ready), 32'd1);
      expect_a(8'h14);
      tick();
      a_valid = 1'b0;
      chk("t4_fifth_accepted", 32'(a_cnt), 32'd4);
      wait_idle_a(200);
      chk("t4_queue_drained", 32'(qa.size()), 32'd0);

      // 5: busy raised mid-frame is ignored; next launch waits for it to drop
      a_valid = 1'b1; a_data = 8'h3C; expect_a(8'h3C);
      tick();
      a_data = 8'h5A; expect_a(8'h5A);
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      tick();
      a_busy = 1'b1;
      n = 0;
      while (a_tx && n < 40) begin
         tick();
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_busy_hold", 32'(a_tx), 32'd0);
      end
      chk("t5_count_waiting", 32'(a_cnt), 32'd1);
      a_busy = 1'b0;
      tick();
      chk("t5_launch_after_busy", 32'(a_tx), 32'd1);
      wait_idle_a(40);
      chk("t5_queue_drained", 32'(qa.size()), 32'd0);

      // 6: reset during data beat 4 with two flits queued
      a_valid = 1'b1; a_data = 8'h33; expect_a(8'h33);
      tick();
      a_data = 8'h44;
      tick();
      a_data = 8'h55;
      tick();
      a_valid = 1'b0;
      chk("t6_count_queued", 32'(a_cnt), 32'd2);
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("t6_in_ready_in_rst", 32'(a_ready), 32'd0);
      qa.delete();
      tick();
      reset = 1'b0;
      chk("t6_serial_zero", 32'(a_ser), 32'd0);
      chk("t6_tx_inactive", 32'(a_tx), 32'd0);
      chk("t6_count_zero", 32'(a_cnt), 32'd0);
      act_a = 0;
      for (int i = 0; i < 20; i++) tick();
      chk("t6_nothing_sent", 32'(act_a), 32'd0);
      chk("t6_count_still_zero", 32'(a_cnt), 32'd0);

`ifdef TX_PARITY_EN
      // Parity beat for 0x07 on one lane is 1
      act_a = 0;
      a_valid = 1'b1; a_data = 8'h07; expect_a(8'h07);
      tick();
      a_valid = 1'b0;
      wait_idle_a(40);
      chk("par_frame_len", 32'(act_a), 32'd10);
      chk("par_queue_drained", 32'(qa.size()), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
